alu_wide_sequencer: RTL and testbench
=====================================

# alu_wide_sequencer

Multi-byte operation sequencer for the 8-bit ALU. It accepts one NBYTES-wide request through a valid/ready handshake and issues one ALU byte operation per cycle, least-significant byte first, using ADD then ADC to chain the carry. It collects the result bytes, forms wide CF/ZF/SF, and returns the result through a valid/ready response port. It is the only master of the ALU's Input_1/Input_2/Instruction/ALU? pins while it is instantiated.

## Interface
- NBYTES, 4, operand width in bytes; legal range 1..8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  0 ADD, 1 AND, 2 OR, 3 XOR, 4 NOT(a), 5 SHL1(a), 6 INC(a), 7 reserved.
- req_a, req_b  in  8*NBYTES  operands; req_b is ignored for ops 4/5/6.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  8*NBYTES  wide result.
- rsp_cf, rsp_zf, rsp_sf, rsp_err  out  1 each  wide flags; rsp_err is set for reserved ops.
- alu_in1, alu_in2  out  8  ALU operand bytes.
- alu_instr  out  8  ALU instruction byte.
- alu_en  out  1  drives the ALU "ALU?" flag-save enable.
- alu_out  in  8  ALU combinational result.
- alu_cf  in  1  ALU registered carry flag.

## Operation
- ALU codes: ADD 0x00, ADC 0x01, NOT 0x08, AND 0x09, OR 0x0A, XOR 0x0B. The ALU saves CF whenever an adder code is selected, regardless of alu_en.
  - Outside RUN, drive alu_instr = 0x08, alu_in1/alu_in2 = 0, alu_en = 0, so the carry flag is never disturbed.
- States are IDLE, RUN, FIN, RESP.
- **IDLE**
  - req_ready = 1.
  - On req_valid with op ≤ 6: latch the operands and op, set idx = 0 and nz = 0, clear the result register, go to RUN.
  - On req_valid with op = 7: go to RESP with result 0, all flags 0, rsp_err = 1. No ALU cycle is issued.
- **RUN** (one byte per cycle)
  - alu_en = 1; alu_in1 = a[idx].
  - ADD: alu_in2 = b[idx]. SHL1: alu_in2 = a[idx]. INC: alu_in2 = (idx == 0) ? 0x01 : 0x00.
  - Adder ops (ADD, SHL1, INC) use code 0x00 at idx 0 and 0x01 at idx > 0.
  - Logical ops use their own code for every byte; NOT puts 0 on alu_in2.
  - At the clock edge: result[idx] ← alu_out; nz ← nz | (alu_out ≠ 0); idx increments.
  - After the edge with idx = NBYTES-1, go to FIN.
- **FIN** (one cycle, ALU idle)
  - rsp_cf ← alu_cf for adder ops, 0 for logical ops.
  - rsp_zf ← ~nz; rsp_sf ← result MSB; rsp_err ← 0.
  - Go to RESP.
- **RESP**
  - rsp_valid = 1. rsp_result and all rsp_* flags stay stable until rsp_valid & rsp_ready, then go to IDLE.
  - Output values persist after the handshake until the next response is loaded.
- Arithmetic wraps modulo 2^(8·NBYTES). The carry out of the top byte appears only in rsp_cf.

## Timing
- Reset values: req_ready 0 while rst is high, 1 in the first cycle after reset. rsp_valid 0, rsp_result 0, all rsp flags 0, alu_en 0, alu_instr 0x08, alu_in1/alu_in2 0, state IDLE.
- rst during any state aborts the operation at that edge. Partial results are discarded and no response is produced.
- Latency, counted from the request-accept edge:
  - rsp_valid rises on edge NBYTES+2 for ops 0..6.
  - rsp_valid rises on edge 1 for op 7.
- Throughput: at best one operation per NBYTES+3 cycles. req_ready is low from accept until the cycle after the response handshake.
- rsp_ready may be high before rsp_valid is asserted; the handshake completes on the first edge where both are high.
- alu_cf sampled in FIN reflects the edge that ended the last RUN cycle.

## Structure
- Package alu_seq_pkg holds:
  - the op enum (3-bit);
  - ALU instruction constants (ADD, ADC, NOT, AND, OR, XOR, and IDLE = NOT);
  - the state enum.
- Single module, no sub-module. Byte select/insert uses an indexed part-select on idx; idx is $clog2(NBYTES) bits, minimum 1.

## Test plan
All scenarios use NBYTES = 4 and a behavioural ALU model with registered CF.
- **Carry chain:** ADD 0x000000FF + 0x00000001 → result 0x00000100, cf 0, zf 0, sf 0. alu_instr sequence is 0x00, 0x01, 0x01, 0x01. rsp_valid rises 6 cycles after accept.
- **Wide overflow:** ADD 0xFFFFFFFF + 0x00000001 → result 0x00000000, cf 1, zf 1, sf 0.
- **Shift and increment:**
  - SHL1 0x80000001 → 0x00000002, cf 1.
  - INC 0x7FFFFFFF → 0x80000000, sf 1, cf 0.
- **Logical ops:**
  - XOR 0xA5A5A5A5 ^ 0xA5A5A5A5 → 0, zf 1, cf 0; alu_instr is 0x0B four times.
  - The ALU CF is unchanged across the idle cycles before and after the operation.
- **Reserved op and backpressure:**
  - op 7 → rsp_err 1, result 0, rsp_valid one cycle after accept, alu_en never asserted.
  - With rsp_ready held low for 5 cycles, the response stays stable and req_ready stays 0.
- **Reset mid-operation:** rst asserted during RUN at idx 2 → next cycle state is IDLE, rsp_valid 0, alu_en 0. A following ADD 1 + 2 returns 3.

Source files
------------

// File: rtl/alu_wide_sequencer_pkg.sv
// rtl/alu_wide_sequencer_pkg.sv - shared types and ALU codes for the wide ALU sequencer
package alu_seq_pkg;

  // Wide operations accepted on the request port
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NOT  = 3'd4,
    OP_SHL1 = 3'd5,
    OP_INC  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  // 8-bit ALU instruction bytes
  localparam logic [7:0] ALU_ADD  = 8'h00;
  localparam logic [7:0] ALU_ADC  = 8'h01;
  localparam logic [7:0] ALU_NOT  = 8'h08;
  localparam logic [7:0] ALU_AND  = 8'h09;
  localparam logic [7:0] ALU_OR   = 8'h0A;
  localparam logic [7:0] ALU_XOR  = 8'h0B;
  // NOT never touches the carry flag, so it is the safe parking code
  localparam logic [7:0] ALU_IDLE = ALU_NOT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Adder-chained ops report the carry out of the top byte
  function automatic logic is_adder_op(op_e op);
    return (op == OP_ADD) || (op == OP_SHL1) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/alu_wide_sequencer_if.sv
// rtl/alu_wide_sequencer_if.sv - request/response ports and ALU pin bundle
interface alu_wide_sequencer_if #(
  parameter int NBYTES = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [8*NBYTES-1:0]   req_a;
  logic [8*NBYTES-1:0]   req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [8*NBYTES-1:0]   rsp_result;
  logic                  rsp_cf;
  logic                  rsp_zf;
  logic                  rsp_sf;
  logic                  rsp_err;
  logic [7:0]            alu_in1;
  logic [7:0]            alu_in2;
  logic [7:0]            alu_instr;
  logic                  alu_en;
  logic [7:0]            alu_out;
  logic                  alu_cf;

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_cf,
    output req_ready, rsp_valid, rsp_result, rsp_cf, rsp_zf, rsp_sf, rsp_err,
    output alu_in1, alu_in2, alu_instr, alu_en
  );

  // Requester plus ALU side
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_cf,
    input  req_ready, rsp_valid, rsp_result, rsp_cf, rsp_zf, rsp_sf, rsp_err,
    input  alu_in1, alu_in2, alu_instr, alu_en
  );
endinterface

// File: rtl/alu_wide_sequencer.sv
// rtl/alu_wide_sequencer.sv - byte-serial wide operation sequencer driving an 8-bit ALU
module alu_wide_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_wide_sequencer_if.slave  bus
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SELW = IDXW + 3;

  state_e           r_state;
  state_e           w_next;
  logic [IDXW-1:0]  r_idx;
  op_e              r_op;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_result;
  logic             r_nz;
  logic [W-1:0]     r_rsp_result;
  logic             r_rsp_cf;
  logic             r_rsp_zf;
  logic             r_rsp_sf;
  logic             r_rsp_err;

  logic [SELW-1:0]  w_sel;
  logic [7:0]       w_a_byte;
  logic [7:0]       w_b_byte;
  logic             w_first;
  logic             w_last;
  op_e              w_req_op;
  logic [7:0]       w_in1;
  logic [7:0]       w_in2;
  logic [7:0]       w_instr;
  logic             w_en;

  assign w_sel    = {r_idx, 3'b000};
  assign w_a_byte = r_a[w_sel +: 8];
  assign w_b_byte = r_b[w_sel +: 8];
  assign w_first  = (r_idx == '0);
  assign w_last   = (r_idx == IDXW'(NBYTES - 1));
  assign w_req_op = op_e'(bus.req_op);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and ALU pin drive; ALU is parked on NOT outside RUN
  always_comb begin
    w_next  = r_state;
    w_instr = ALU_IDLE;
    w_in1   = 8'h00;
    w_in2   = 8'h00;
    w_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_next = (w_req_op == OP_RSVD) ? ST_RESP : ST_RUN;
        end
      end
      ST_RUN: begin
        w_en  = 1'b1;
        w_in1 = w_a_byte;
        case (r_op)
          OP_ADD: begin
            w_in2   = w_b_byte;
            w_instr = w_first ? ALU_ADD : ALU_ADC;
          end
          OP_SHL1: begin
            w_in2   = w_a_byte;
            w_instr = w_first ? ALU_ADD : ALU_ADC;
          end
          OP_INC: begin
            w_in2   = w_first ? 8'h01 : 8'h00;
            w_instr = w_first ? ALU_ADD : ALU_ADC;
          end
          OP_AND: begin
            w_in2   = w_b_byte;
            w_instr = ALU_AND;
          end
          OP_OR: begin
            w_in2   = w_b_byte;
            w_instr = ALU_OR;
          end
          OP_XOR: begin
            w_in2   = w_b_byte;
            w_instr = ALU_XOR;
          end
          default: begin
            w_instr = ALU_NOT;
          end
        endcase
        if (w_last) begin
          w_next = ST_FIN;
        end
      end
      ST_FIN: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Operand latch, byte collection and response flag formation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_op         <= OP_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_nz         <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cf     <= 1'b0;
      r_rsp_zf     <= 1'b0;
      r_rsp_sf     <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (w_req_op == OP_RSVD) begin
              r_rsp_result <= '0;
              r_rsp_cf     <= 1'b0;
              r_rsp_zf     <= 1'b0;
              r_rsp_sf     <= 1'b0;
              r_rsp_err    <= 1'b1;
            end else begin
              r_a      <= bus.req_a;
              r_b      <= bus.req_b;
              r_op     <= w_req_op;
              r_idx    <= '0;
              r_nz     <= 1'b0;
              r_result <= '0;
            end
          end
        end
        ST_RUN: begin
          r_result[w_sel +: 8] <= bus.alu_out;
          r_nz                 <= r_nz | (bus.alu_out != 8'h00);
          r_idx                <= r_idx + IDXW'(1);
        end
        ST_FIN: begin
          r_rsp_result <= r_result;
          r_rsp_cf     <= is_adder_op(r_op) ? bus.alu_cf : 1'b0;
          r_rsp_zf     <= ~r_nz;
          r_rsp_sf     <= r_result[W-1];
          r_rsp_err    <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE) & ~rst;
  assign bus.rsp_valid  = (r_state == ST_RESP);
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_cf     = r_rsp_cf;
  assign bus.rsp_zf     = r_rsp_zf;
  assign bus.rsp_sf     = r_rsp_sf;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.alu_in1    = w_in1;
  assign bus.alu_in2    = w_in2;
  assign bus.alu_instr  = w_instr;
  assign bus.alu_en     = w_en;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb/tb_alu_wide_sequencer.sv - self-checking bench with ALU model, vector table and random ops
module tb_alu_wide_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_wide_sequencer_if #(.NBYTES(4)) bus ();

  alu_wide_sequencer #(.NBYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural 8-bit ALU: combinational result, carry registered on adder codes
  logic       tb_cf = 1'b0;
  logic [8:0] alu_sum;
  logic [7:0] alu_res;
  always_comb begin
    alu_sum = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2} +
              {8'h00, (bus.alu_instr == 8'h01) ? tb_cf : 1'b0};
    case (bus.alu_instr)
      8'h00, 8'h01: alu_res = alu_sum[7:0];
      8'h08:        alu_res = ~bus.alu_in1;
      8'h09:        alu_res = bus.alu_in1 & bus.alu_in2;
      8'h0A:        alu_res = bus.alu_in1 | bus.alu_in2;
      8'h0B:        alu_res = bus.alu_in1 ^ bus.alu_in2;
      default:      alu_res = 8'h00;
    endcase
  end
  assign bus.alu_out = alu_res;
  assign bus.alu_cf  = tb_cf;

  always @(posedge clk) begin
    if (bus.alu_instr == 8'h00 || bus.alu_instr == 8'h01) tb_cf <= alu_sum[8];
  end

  logic [7:0] instr_log[$];
  int         en_count = 0;
  always @(posedge clk) begin
    if (bus.alu_en) begin
      instr_log.push_back(bus.alu_instr);
      en_count <= en_count + 1;
    end
  end

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic on the operands
  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic cf, output logic zf,
                           output logic sf, output logic err);
    logic [32:0] s;
    s = 33'd0;
    err = 1'b0;
    case (op)
      3'd0: s = {1'b0, a} + {1'b0, b};
      3'd1: s = {1'b0, a & b};
      3'd2: s = {1'b0, a | b};
      3'd3: s = {1'b0, a ^ b};
      3'd4: s = {1'b0, ~a};
      3'd5: s = {1'b0, a} * 33'd2;
      3'd6: s = {1'b0, a} + 33'd1;
      default: begin s = 33'd0; err = 1'b1; end
    endcase
    res = s[31:0];
    cf  = s[32];
    zf  = (op == 3'd7) ? 1'b0 : (res == 32'd0);
    sf  = res[31];
  endtask

  // One transaction. hold = 0 raises rsp_ready before the request;
  // otherwise rsp_ready stays low for hold cycles of valid response.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] res, output logic [3:0] flags,
                       output int lat, output logic stable);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    res    = bus.rsp_result;
    flags  = {bus.rsp_cf, bus.rsp_zf, bus.rsp_sf, bus.rsp_err};
    stable = 1'b1;
    if (!bus.rsp_valid) begin
      chk("rsp_timeout", 64'(lat), 64'd0);
      bus.rsp_ready = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.req_ready || bus.rsp_result !== res ||
          {bus.rsp_cf, bus.rsp_zf, bus.rsp_sf, bus.rsp_err} !== flags)
        stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;   // {cf, zf, sf, err}
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] res, eres;
    logic [3:0]  fl;
    logic        ecf, ezf, esf, eerr, stable, cf_before;
    int          lat, base, en_before;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{"add_carry_chain", 3'd0, 32'h000000FF, 32'h00000001, 32'h00000100, 4'b0000, 6};
    vecs[1] = '{"add_overflow",    3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100, 6};
    vecs[2] = '{"shl1",            3'd5, 32'h80000001, 32'h12345678, 32'h00000002, 4'b1000, 6};
    vecs[3] = '{"inc",             3'd6, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b0010, 6};
    vecs[4] = '{"xor_zero",        3'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b0100, 6};
    vecs[5] = '{"and",             3'd1, 32'hF0F0FF00, 32'h8F0F0FF0, 32'h80000F00, 4'b0010, 6};
    vecs[6] = '{"or",              3'd2, 32'h00120000, 32'h00003400, 32'h00123400, 4'b0000, 6};
    vecs[7] = '{"not",             3'd4, 32'h0000FFFF, 32'h00000000, 32'hFFFF0000, 4'b0010, 6};
    vecs[8] = '{"reserved",        3'd7, 32'h11111111, 32'h22222222, 32'h00000000, 4'b0001, 1};

    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("reset_flags", 64'({bus.rsp_cf, bus.rsp_zf, bus.rsp_sf, bus.rsp_err}), 64'd0);
    chk("reset_alu_pins", 64'({bus.alu_en, bus.alu_instr, bus.alu_in1, bus.alu_in2}), 64'h0_08_00_00);

    // Table vectors
    for (int v = 0; v < 9; v++) begin
      base      = instr_log.size();
      en_before = en_count;
      cf_before = tb_cf;
      do_op(vecs[v].op, vecs[v].a, vecs[v].b, 0, res, fl, lat, stable);
      chk({vecs[v].name, "_result"}, 64'(res), 64'(vecs[v].res));
      chk({vecs[v].name, "_flags"}, 64'(fl), 64'(vecs[v].flags));
      chk({vecs[v].name, "_latency"}, 64'(lat), 64'(vecs[v].lat));
      chk({vecs[v].name, "_ready_after"}, 64'(bus.req_ready), 64'd1);
      if (v == 0) begin
        chk("carry_instr_count", 64'(instr_log.size() - base), 64'd4);
        if (instr_log.size() - base == 4)
          chk("carry_instr_seq", 64'({instr_log[base], instr_log[base+1], instr_log[base+2], instr_log[base+3]}),
              64'h00010101);
        @(negedge clk);
        chk("result_persists", 64'(bus.rsp_result), 64'h100);
      end
      if (v == 4) begin
        chk("xor_instr_count", 64'(instr_log.size() - base), 64'd4);
        if (instr_log.size() - base == 4)
          chk("xor_instr_seq", 64'({instr_log[base], instr_log[base+1], instr_log[base+2], instr_log[base+3]}),
              64'h0B0B0B0B);
        repeat (3) @(negedge clk);
        chk("xor_cf_preserved", 64'(tb_cf), 64'(cf_before));
      end
      if (v == 8) chk("reserved_no_alu", 64'(en_count - en_before), 64'd0);
    end

    // Backpressure: response held for 5 cycles
    do_op(3'd0, 32'h12345678, 32'h11111111, 5, res, fl, lat, stable);
    chk("bp_result", 64'(res), 64'h23456789);
    chk("bp_stable", 64'(stable), 64'd1);

    // Reset during RUN at idx 2
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'hFFFFFFFF;
    bus.req_b     = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_alu_en", 64'(bus.alu_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_alu_en", 64'(bus.alu_en), 64'd0);
    @(negedge clk);
    chk("abort_idle", 64'(bus.req_ready), 64'd1);
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) chk("abort_no_response", 64'd1, 64'd0);
    end
    do_op(3'd0, 32'd1, 32'd2, 1, res, fl, lat, stable);
    chk("post_reset_add", 64'(res), 64'd3);
    chk("post_reset_flags", 64'(fl), 64'd0);

    // Random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if (n % 5 == 0) ra = 32'hFFFFFFFF;
      ref_model(rop, ra, rb, eres, ecf, ezf, esf, eerr);
      do_op(rop, ra, rb, $urandom_range(0, 3), res, fl, lat, stable);
      chk($sformatf("rand%0d_op%0d_result", n, rop), 64'(res), 64'(eres));
      chk($sformatf("rand%0d_op%0d_flags", n, rop), 64'(fl), 64'({ecf, ezf, esf, eerr}));
      chk($sformatf("rand%0d_latency", n), 64'(lat), (rop == 3'd7) ? 64'd1 : 64'd6);
      chk($sformatf("rand%0d_stable", n), 64'(stable), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
